uart_arbiter: RTL

Sequencer and two-way arbiter sitting between the SD host's byte producers and the `uart` block. It owns the uart's `ctrl` byte, sharing the transmitter between two requesters with round-robin fairness and issuing one `tx_start` per byte. It also buffers one received byte behind a valid/ready handshake and acknowledges the uart's `rx_done`. It replaces the free-running `register` loop that fed `uart_state` straight back into `ctrl`.

---
 rtl/uart_arb_pkg.sv | 20 ++
 rtl/uart_rr_arb.sv | 18 +
 rtl/uart_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and bit positions for the uart arbiter: TX sequencer states and
// the field layout of the uart ctrl/state bytes.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_START,
    TX_WAIT
  } tx_state_e;

  localparam int unsigned CTRL_RX_EN    = 0;
  localparam int unsigned CTRL_TX_START = 1;
  localparam int unsigned CTRL_RX_ACK   = 2;

  localparam int unsigned ST_TX_BUSY = 0;
  localparam int unsigned ST_TX_DONE = 1;
  localparam int unsigned ST_RX_DONE = 2;

endpackage

// File: rtl/uart_rr_arb.sv
// Two-way round-robin select: a lone requester wins, on contention the one
// that did not win last time wins.
module uart_rr_arb (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       sel
);

  always_comb begin
    sel = 1'b0;
    if (valid == 2'b11) begin
      sel = ~last_grant;
    end else if (valid[1]) begin
      sel = 1'b1;
    end
  end

endmodule

// File: rtl/uart_arbiter.sv
// TX sequencer/arbiter and one-byte RX buffer in front of the uart block.
// Optional TX completion watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  input  logic       rx_ready,
  output logic [7:0] uart_tx_data,
  input  logic [7:0] uart_rx_data,
  output logic [7:0] uart_ctrl,
  input  logic [7:0] uart_state,
  output logic       grant_id,
  output logic       busy,
  output logic       tx_timeout
);

  tx_state_e  state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_ack_q, blank_q;
  logic       sel, handshake, capture, timeout_hit, tx_done;
  logic       unused_state;

  assign tx_done = uart_state[ST_TX_DONE];
  assign unused_state = ^{uart_state[7:3], uart_state[ST_TX_BUSY], TIMEOUT_CYCLES[0]};

  uart_rr_arb u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .sel        (sel)
  );

  assign req0_ready = (state_q == TX_IDLE) && req0_valid && !sel;
  assign req1_ready = (state_q == TX_IDLE) && req1_valid && sel;
  assign handshake  = req0_ready || req1_ready;

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      TX_IDLE: begin
        if (handshake) begin
          tx_data_d    = sel ? req1_data : req0_data;
          grant_d      = sel;
          last_grant_d = sel;
          state_d      = TX_LOAD;
        end
      end
      TX_LOAD:  state_d = TX_START;
      TX_START: state_d = TX_WAIT;
      TX_WAIT:  if (tx_done || timeout_hit) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_q;

  // tx_done in the limit cycle takes priority, so no pulse is raised then.
  assign timeout_hit = (state_q == TX_WAIT) && !tx_done && (wd_cnt_q == LIMIT);

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q != TX_WAIT) begin
      wd_cnt_d = '0;
    end else if (!timeout_hit) begin
      wd_cnt_d = wd_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_hit;
    end
  end

  assign tx_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign tx_timeout  = 1'b0;
`endif

  // The uart only sees rx_ack at the edge after the pulse, so rx_done can still
  // be high for the ack cycle and the one after; both are blanked.
  assign capture = uart_state[ST_RX_DONE] && !rx_ack_q && !blank_q &&
                   (!rx_valid_q || rx_ready);

  always_comb begin
    rx_byte_d  = capture ? uart_rx_data : rx_byte_q;
    rx_valid_d = capture || (rx_valid_q && !rx_ready);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= TX_IDLE;
      tx_data_q    <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rx_valid_q   <= 1'b0;
      rx_byte_q    <= '0;
      rx_ack_q     <= 1'b0;
      blank_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rx_valid_q   <= rx_valid_d;
      rx_byte_q    <= rx_byte_d;
      rx_ack_q     <= capture;
      blank_q      <= rx_ack_q;
    end
  end

  always_comb begin
    uart_ctrl                = '0;
    uart_ctrl[CTRL_RX_EN]    = !rx_valid_q;
    uart_ctrl[CTRL_TX_START] = (state_q == TX_START);
    uart_ctrl[CTRL_RX_ACK]   = rx_ack_q;
  end

  assign uart_tx_data = tx_data_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q != TX_IDLE);
  assign rx_valid     = rx_valid_q;
  assign rx_byte      = rx_byte_q;

endmodule
